// File: rtl/core_pkg.sv
// Shared types and constants for the multiply/divide unit.
package core_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_DONE
  } mdu_state_e;

  // Division-family operation (quotient or remainder).
  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  // Remainder operations return the partial remainder instead of the quotient.
  function automatic logic op_is_rem(input mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  // rs1 is interpreted as two's complement.
  function automatic logic op1_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is interpreted as two's complement.
  function automatic logic op2_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  dividend_bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  quot_bit_o
);

  logic [DATA_WIDTH:0] trial;
  logic [DATA_WIDTH:0] diff;

  // Compare-and-restore: keep the difference only when the divisor fits.
  always_comb begin
    trial      = {rem_i, dividend_bit_i};
    diff       = trial - {1'b0, divisor_i};
    quot_bit_o = (trial >= {1'b0, divisor_i});
    rem_o      = quot_bit_o ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_unit.sv
// RV32M-style iterative multiply/divide unit with start/ready handshake,
// one-cycle valid pulse and flush support.
// Optional feature: define MDU_FAST_MUL_EN for single-cycle multiplies.
module mdu_unit
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  mdu_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] operand1_i,
  input  logic [DATA_WIDTH-1:0] operand2_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;

  mdu_state_e       state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  mdu_op_e          op_q;
  logic             neg_q;
  logic [W-1:0]     mcand_q;
  logic [2*W-1:0]   acc_q;
  logic             valid_q;
  logic [W-1:0]     result_q;

  logic             sign1, sign2, neg_init, direct_done;
  logic [W-1:0]     mag1, mag2, mcand_init;
  logic [2*W-1:0]   acc_init;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   step_next;
  logic [W-1:0]     div_rem;
  logic             div_qbit;
`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0]   fast_prod;
`endif

  // Final sign correction and selection of the architectural result.
  function automatic logic [W-1:0] mdu_result(input logic [2*W-1:0] acc,
                                              input mdu_op_e op,
                                              input logic neg);
    logic [2*W-1:0] prod;
    logic [W-1:0]   part;
    prod = neg ? -acc : acc;
    if (op_is_div(op)) begin
      part = op_is_rem(op) ? acc[2*W-1:W] : acc[W-1:0];
      part = neg ? -part : part;
    end else if (op == MDU_MUL) begin
      part = prod[W-1:0];
    end else begin
      part = prod[2*W-1:W];
    end
    return part;
  endfunction

  // Operand preparation on accept: magnitudes, result sign, special cases.
  always_comb begin
    sign1       = op1_signed(op_i) & operand1_i[W-1];
    sign2       = op2_signed(op_i) & operand2_i[W-1];
    mag1        = sign1 ? -operand1_i : operand1_i;
    mag2        = sign2 ? -operand2_i : operand2_i;
    neg_init    = (op_is_div(op_i) && op_is_rem(op_i)) ? sign1 : (sign1 ^ sign2);
    mcand_init  = op_is_div(op_i) ? mag2 : mag1;
    acc_init    = {{W{1'b0}}, (op_is_div(op_i) ? mag1 : mag2)};
    direct_done = 1'b0;
`ifdef MDU_FAST_MUL_EN
    fast_prod   = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif
    if (op_is_div(op_i)) begin
      if (operand2_i == '0) begin
        direct_done = 1'b1;
        neg_init    = 1'b0;
        acc_init    = op_is_rem(op_i) ? {operand1_i, {W{1'b0}}} : {{W{1'b0}}, {W{1'b1}}};
      end else if (op1_signed(op_i) && (operand1_i == {1'b1, {(W-1){1'b0}}}) &&
                   (operand2_i == {W{1'b1}})) begin
        direct_done = 1'b1;
        neg_init    = 1'b0;
        acc_init    = op_is_rem(op_i) ? {2*W{1'b0}} : {{W{1'b0}}, operand1_i};
      end
    end else begin
`ifdef MDU_FAST_MUL_EN
      direct_done = 1'b1;
      acc_init    = fast_prod;
`else
      direct_done = 1'b0;
`endif
    end
  end

  mdu_div_step #(.DATA_WIDTH(W)) u_div_step (
    .rem_i          (acc_q[2*W-1:W]),
    .dividend_bit_i (acc_q[W-1]),
    .divisor_i      (mcand_q),
    .rem_o          (div_rem),
    .quot_bit_o     (div_qbit)
  );

  // One radix-2 iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (op_is_div(op_q)) begin
      step_next = {div_rem, acc_q[W-2:0], div_qbit};
    end else begin
      step_next = {mul_sum, acc_q[W-1:1]};
    end
  end

  // Control FSM with registered result and valid pulse; flush beats start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= MDU_IDLE;
      end else begin
        case (state_q)
          MDU_IDLE: begin
            if (start_i) begin
              op_q    <= op_i;
              neg_q   <= neg_init;
              mcand_q <= mcand_init;
              acc_q   <= acc_init;
              cnt_q   <= CNT_WIDTH'(W);
              if (direct_done) begin
                result_q <= mdu_result(acc_init, op_i, neg_init);
                valid_q  <= 1'b1;
                state_q  <= MDU_DONE;
              end else begin
                state_q  <= MDU_CALC;
              end
            end
          end
          MDU_CALC: begin
            acc_q <= step_next;
            cnt_q <= cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
              result_q <= mdu_result(step_next, op_q, neg_q);
              valid_q  <= 1'b1;
              state_q  <= MDU_DONE;
            end
          end
          MDU_DONE: state_q <= MDU_IDLE;
          default:  state_q <= MDU_IDLE;
        endcase
      end
    end
  end

  // Handshake outputs derived from the state register.
  always_comb begin
    ready_o  = (state_q == MDU_IDLE);
    busy_o   = !ready_o;
    valid_o  = valid_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed RV32M cases, random operations
// against a 64-bit arithmetic reference model, flush/reset/handshake checks.
module tb_mdu_unit;
  import core_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  mdu_op_e       op_i;
  logic [W-1:0]  operand1_i;
  logic [W-1:0]  operand2_i;
  logic          flush_i;
  logic          ready_o;
  logic          busy_o;
  logic          valid_o;
  logic [W-1:0]  result_o;

  typedef struct {
    logic [W-1:0] result;
    int unsigned  cycle;
    mdu_op_e      op;
  } exp_t;

  exp_t         scoreboard[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int unsigned  cyc = 0;
  logic [W-1:0] last_expected = '0;

  mdu_unit #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  // Reference model straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [W-1:0] ref_model(input mdu_op_e op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sbv = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          p;
    longint unsigned up;
    logic            ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MDU_MUL:    begin p = sa * sbv; return p[31:0]; end
      MDU_MULH:   begin p = sa * sbv; return p[63:32]; end
      MDU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MDU_MULHU:  begin up = ua * ub; return up[63:32]; end
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sbv; return p[31:0];
      end
      MDU_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sbv; return p[31:0];
      end
      MDU_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  // Cycles from accept to the valid pulse.
  function automatic int unsigned expected_latency(input mdu_op_e op, input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
    bit is_div = op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    if (is_div && b == 0) return 1;
    if ((op == MDU_DIV || op == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!is_div) return 1;
`endif
    return W + 1;
  endfunction

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) checkOutput("ready_timeout", {63'd0, ready_o}, 64'd1);
  endtask

  // Issue one operation; optionally register its expected response.
  task automatic applyStimulus(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit expect_result, output int unsigned t0);
    exp_t e;
    waitReady();
    op_i       = op;
    operand1_i = a;
    operand2_i = b;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t0 = cyc;
    if (expect_result) begin
      e.result = ref_model(op, a, b);
      e.cycle  = t0 + expected_latency(op, a, b) - 1;
      e.op     = op;
      scoreboard.push_back(e);
      last_expected = e.result;
    end
    checkOutput("busy_after_accept", {62'd0, busy_o, ready_o}, 64'd2);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        if (scoreboard.size() == 0) begin
          checkOutput("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = scoreboard.pop_front();
          checkOutput($sformatf("result_%s", e.op.name()), {32'd0, result_o}, {32'd0, e.result});
          checkOutput($sformatf("valid_cycle_%s", e.op.name()), {32'd0, cyc}, {32'd0, e.cycle});
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int unsigned t0;
    int          n;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = MDU_MUL;
    operand1_i = '0;
    operand2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {29'd0, ready_o, busy_o, valid_o, result_o}, {29'd0, 3'b100, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations from the RV32M corner list.
    applyStimulus(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 1, t0);
    applyStimulus(MDU_MULH,   32'd7,          32'hFFFF_FFFD, 1, t0);
    applyStimulus(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, t0);
    applyStimulus(MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, t0);
    applyStimulus(MDU_DIV,    32'hFFFF_FFEC,  32'd3,         1, t0);
    applyStimulus(MDU_REM,    32'hFFFF_FFEC,  32'd3,         1, t0);
    applyStimulus(MDU_DIVU,   32'd100,        32'd7,         1, t0);
    applyStimulus(MDU_REMU,   32'd100,        32'd7,         1, t0);
    applyStimulus(MDU_DIVU,   32'd5,          32'd0,         1, t0);
    applyStimulus(MDU_REM,    32'd5,          32'd0,         1, t0);
    applyStimulus(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1, t0);
    applyStimulus(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1, t0);
    applyStimulus(MDU_MUL,    32'd6,          32'd7,         1, t0);

    // Start while busy must be ignored: only the DIVU result may appear.
    applyStimulus(MDU_DIVU, 32'd1000, 32'd7, 1, t0);
    repeat (3) @(negedge clk);
    op_i = MDU_MUL; operand1_i = 32'd3; operand2_i = 32'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    // Flush of an in-flight DIV: no valid, result held.
    applyStimulus(MDU_DIV, 32'hFFFF_FFEC, 32'd3, 0, t0);
    while (cyc < t0 + 9) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checkOutput("flush_to_idle", {62'd0, ready_o, busy_o}, 64'd2);
    checkOutput("flush_result_held", {32'd0, result_o}, {32'd0, last_expected});
    repeat (W + 4) @(negedge clk);
    checkOutput("flush_no_late_valid", {63'd0, valid_o}, 64'd0);

    // Flush together with start in IDLE: start is dropped.
    @(negedge clk);
    op_i = MDU_DIVU; operand1_i = 32'd9; operand2_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0; flush_i = 1'b0;
    checkOutput("flush_beats_start", {63'd0, ready_o}, 64'd1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(mdu_op_e'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1, t0);
    end

    // Reset in the middle of a DIV clears everything.
    applyStimulus(MDU_DIV, 32'd12345, 32'd17, 0, t0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_mid_op", {29'd0, ready_o, busy_o, valid_o, result_o}, {29'd0, 3'b100, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    last_expected = '0;
    repeat (W + 4) @(negedge clk);
    checkOutput("reset_no_late_valid", {63'd0, valid_o}, 64'd0);

    // Drain outstanding expectations.
    n = 0;
    while (scoreboard.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", 64'(scoreboard.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
